// File: rtl/ds2_pkg.sv
// rtl/ds2_pkg.sv - shared DualShock2 button map, stick constants and input-vector layout
package ds2_pkg;

   // Button bit positions within ds2_btn
   localparam int BTN_SEL    = 0;
   localparam int BTN_R3     = 1;
   localparam int BTN_L3     = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_RIGHT  = 5;
   localparam int BTN_DOWN   = 6;
   localparam int BTN_LEFT   = 7;
   localparam int BTN_L2     = 8;
   localparam int BTN_R2     = 9;
   localparam int BTN_L1     = 10;
   localparam int BTN_R1     = 11;
   localparam int BTN_TRI    = 12;
   localparam int BTN_CIRC   = 13;
   localparam int BTN_CROSS  = 14;
   localparam int BTN_SQUARE = 15;

   localparam logic [7:0] STICK_CENTRE = 8'h80;
   localparam int         DEADZONE_DEF = 32;

   // Input vector is {buttons[15:0], lx[7:0], ly[7:0]}
   localparam int               VEC_W   = 32;
   localparam logic [VEC_W-1:0] VEC_RST = {16'h0000, STICK_CENTRE, STICK_CENTRE};

endpackage

// File: rtl/ds2_frame_sampler.sv
// rtl/ds2_frame_sampler.sv - synchronizes the DS2 vector and vsync, filters glitches, latches one vector per frame
module ds2_frame_sampler
   import ds2_pkg::*;
#(
   parameter int STABLE_CYC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vsync,
   input  logic [VEC_W-1:0] vec,
   output logic             frame_evt,
   output logic [VEC_W-1:0] nxt_vec,
   output logic [VEC_W-1:0] cur_vec,
   output logic             frame_tick
);

   localparam int CW = $clog2(STABLE_CYC + 1);

   logic [VEC_W-1:0] vec_s1, vec_s2, vec_d, acc;
   logic             vs_s1, vs_s2, vs_d;
   logic [CW-1:0]    stab_cnt;
   logic             same, accept;

   // A sample counts toward stability only if it equals the one before it
   assign same      = (vec_s2 == vec_d);
   assign accept    = same && (stab_cnt >= CW'(STABLE_CYC - 1));
   // A frame landing on the acceptance cycle sees the freshly accepted value
   assign nxt_vec   = accept ? vec_s2 : acc;
   assign frame_evt = vs_s2 & ~vs_d;

   // Two-flop synchronizers plus one delay stage for compare/edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_s1 <= VEC_RST;
         vec_s2 <= VEC_RST;
         vec_d  <= VEC_RST;
         vs_s1  <= 1'b0;
         vs_s2  <= 1'b0;
         vs_d   <= 1'b0;
      end else begin
         vec_s1 <= vec;
         vec_s2 <= vec_s1;
         vec_d  <= vec_s2;
         vs_s1  <= vsync;
         vs_s2  <= vs_s1;
         vs_d   <= vs_s2;
      end
   end

   // Stability counter: restarts on any change, saturates at STABLE_CYC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stab_cnt <= '0;
         acc      <= VEC_RST;
      end else begin
         if (!same)
            stab_cnt <= CW'(1);
         else if (stab_cnt != CW'(STABLE_CYC))
            stab_cnt <= stab_cnt + CW'(1);
         if (accept)
            acc <= vec_s2;
      end
   end

   // Per-frame latch of the accepted vector; cur_vec serves as prev for the next frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_vec    <= VEC_RST;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_evt;
         if (frame_evt)
            cur_vec <= nxt_vec;
      end
   end

endmodule

// File: rtl/ds2_a2600_joy.sv
// rtl/ds2_a2600_joy.sv - DS2 to Atari 2600 joystick/paddle mapper; paddle built only with DS2_A2600_PADDLE_EN
module ds2_a2600_joy
   import ds2_pkg::*;
#(
   parameter int STABLE_CYC   = 4,
   parameter int DEADZONE     = DEADZONE_DEF,
   parameter int AUTOFIRE_DIV = 4,
   parameter int PADDLE_SHIFT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vsync,
   input  logic [15:0] ds2_btn,
   input  logic [7:0]  ds2_lx,
   input  logic [7:0]  ds2_ly,
   output logic        joy_up,
   output logic        joy_down,
   output logic        joy_left,
   output logic        joy_right,
   output logic        joy_fire,
   output logic [7:0]  paddle_pos,
   output logic        paddle_fire,
   output logic        analog_mode,
   output logic        autofire_on,
   output logic        frame_tick
);

   localparam logic [7:0] LO_TH = STICK_CENTRE - 8'(DEADZONE);
   localparam logic [7:0] HI_TH = 8'h7F + 8'(DEADZONE);

   logic             frame_evt;
   logic [VEC_W-1:0] nxt_vec, cur_vec;
   logic [15:0]      b, pb;
   logic [7:0]       lx, ly;
   logic             press_start, press_r1;
   logic             mode_n, af_n, phase, phase_n;
   logic [3:0]       af_cnt, cnt_n;
   logic             l_raw, r_raw, u_raw, d_raw, fire_n;
   logic             unused_bits;

   ds2_frame_sampler #(.STABLE_CYC(STABLE_CYC)) u_sampler (
      .clk        (clk),
      .rst_n      (rst_n),
      .vsync      (vsync),
      .vec        ({ds2_btn, ds2_lx, ds2_ly}),
      .frame_evt  (frame_evt),
      .nxt_vec    (nxt_vec),
      .cur_vec    (cur_vec),
      .frame_tick (frame_tick)
   );

   assign b           = nxt_vec[31:16];
   assign lx          = nxt_vec[15:8];
   assign ly          = nxt_vec[7:0];
   assign pb          = cur_vec[31:16];
   assign press_start = b[BTN_START] & ~pb[BTN_START];
   assign press_r1    = b[BTN_R1] & ~pb[BTN_R1];

   // Buttons and fields with no Atari mapping
   assign unused_bits = ^{b[BTN_R3], b[BTN_L3], b[BTN_L2], b[BTN_R2], b[BTN_TRI],
                          b[BTN_L1], b[BTN_CIRC], pb, cur_vec[15:0], 4'(PADDLE_SHIFT)};

   // Next-frame mode, autofire phase, directions and fire
   always_comb begin
      mode_n  = analog_mode ^ (press_start & b[BTN_SEL]);
      af_n    = autofire_on ^ press_r1;
      phase_n = phase;
      cnt_n   = af_cnt;
      if (!af_n) begin
         phase_n = 1'b0;
         cnt_n   = 4'd0;
      end else if (autofire_on) begin
         if (af_cnt == 4'(AUTOFIRE_DIV - 1)) begin
            cnt_n   = 4'd0;
            phase_n = ~phase;
         end else begin
            cnt_n = af_cnt + 4'd1;
         end
      end
      l_raw  = b[BTN_LEFT]  | (mode_n & (lx < LO_TH));
      r_raw  = b[BTN_RIGHT] | (mode_n & (lx > HI_TH));
      u_raw  = b[BTN_UP]    | (mode_n & (ly < LO_TH));
      d_raw  = b[BTN_DOWN]  | (mode_n & (ly > HI_TH));
      fire_n = b[BTN_CROSS] | (b[BTN_SQUARE] & (af_n ? phase_n : 1'b1));
   end

   // Joystick outputs and mode state update once per frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         joy_up      <= 1'b0;
         joy_down    <= 1'b0;
         joy_left    <= 1'b0;
         joy_right   <= 1'b0;
         joy_fire    <= 1'b0;
         analog_mode <= 1'b0;
         autofire_on <= 1'b0;
         phase       <= 1'b0;
         af_cnt      <= 4'd0;
      end else if (frame_evt) begin
         joy_left    <= l_raw & ~r_raw;
         joy_right   <= r_raw & ~l_raw;
         joy_up      <= u_raw & ~d_raw;
         joy_down    <= d_raw & ~u_raw;
         joy_fire    <= fire_n;
         analog_mode <= mode_n;
         autofire_on <= af_n;
         phase       <= phase_n;
         af_cnt      <= cnt_n;
      end
   end

`ifdef DS2_A2600_PADDLE_EN
   logic              press_l1;
   logic signed [8:0] offset, offset_abs, step;
   logic signed [9:0] pad_sum;
   logic [7:0]        pad_n;

   assign press_l1 = b[BTN_L1] & ~pb[BTN_L1];

   // Saturating paddle integrator; L1 recentre wins over motion
   always_comb begin
      offset     = $signed({1'b0, lx}) - $signed({1'b0, STICK_CENTRE});
      offset_abs = offset[8] ? -offset : offset;
      step       = offset >>> PADDLE_SHIFT;
      pad_sum    = $signed({2'b00, paddle_pos}) + $signed({step[8], step});
      pad_n      = paddle_pos;
      if (press_l1)
         pad_n = STICK_CENTRE;
      else if (offset_abs > 9'(DEADZONE)) begin
         if (pad_sum[9])
            pad_n = 8'h00;
         else if (pad_sum[8])
            pad_n = 8'hFF;
         else
            pad_n = pad_sum[7:0];
      end
   end

   // Paddle outputs update once per frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         paddle_pos  <= STICK_CENTRE;
         paddle_fire <= 1'b0;
      end else if (frame_evt) begin
         paddle_pos  <= pad_n;
         paddle_fire <= b[BTN_CIRC];
      end
   end
`else
   assign paddle_pos  = STICK_CENTRE;
   assign paddle_fire = 1'b0;
`endif

endmodule

// File: tb/tb_ds2_a2600_joy.sv
// tb/tb_ds2_a2600_joy.sv - scoreboard bench for ds2_a2600_joy
module tb_ds2_a2600_joy;

`ifdef DS2_A2600_PADDLE_EN
   localparam bit PADDLE_BUILT = 1'b1;
`else
   localparam bit PADDLE_BUILT = 1'b0;
`endif

   localparam logic [15:0] SEL = 16'h0001, START = 16'h0008, UP = 16'h0010, RIGHT = 16'h0020;
   localparam logic [15:0] DOWN = 16'h0040, LEFT = 16'h0080, L1 = 16'h0400, R1 = 16'h0800;
   localparam logic [15:0] CIRC = 16'h2000, CROSS = 16'h4000, SQUARE = 16'h8000;
   localparam logic [4:0]  U = 5'b10000, D = 5'b01000, L = 5'b00100, R = 5'b00010, F = 5'b00001;

   logic        clk = 1'b0, rst_n = 1'b0, vsync = 1'b0;
   logic [15:0] ds2_btn = 16'h0;
   logic [7:0]  ds2_lx = 8'h80, ds2_ly = 8'h80;
   logic        joy_up, joy_down, joy_left, joy_right, joy_fire;
   logic [7:0]  paddle_pos;
   logic        paddle_fire, analog_mode, autofire_on, frame_tick;

   int          n_checks = 0, n_pass = 0, n_frames = 0;
   logic [15:0] exp_q[$];
   int          tag_q[$];
   logic [7:0]  m_pad = 8'h80;
   logic [15:0] last_b = 16'h0;
   logic [15:0] got;

   ds2_a2600_joy dut (
      .clk(clk), .rst_n(rst_n), .vsync(vsync), .ds2_btn(ds2_btn), .ds2_lx(ds2_lx), .ds2_ly(ds2_ly),
      .joy_up(joy_up), .joy_down(joy_down), .joy_left(joy_left), .joy_right(joy_right),
      .joy_fire(joy_fire), .paddle_pos(paddle_pos), .paddle_fire(paddle_fire),
      .analog_mode(analog_mode), .autofire_on(autofire_on), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   assign got = {joy_up, joy_down, joy_left, joy_right, joy_fire, paddle_pos, paddle_fire, analog_mode, autofire_on};

   function automatic logic [15:0] mk(input logic [4:0] udlrf, input logic [7:0] pad,
                                      input logic pf, input logic an, input logic af);
      return {udlrf, pad, pf, an, af};
   endfunction

   function automatic logic [7:0] pad_next(input logic [7:0] pos, input logic [7:0] x, input logic l1p);
      int off, p;
      if (!PADDLE_BUILT) return 8'h80;
      if (l1p) return 8'h80;
      off = int'(x) - 128;
      p = int'(pos);
      if (off > 32 || off < -32) p = p + (off >>> 3);
      if (p < 0) p = 0;
      if (p > 255) p = 255;
      return 8'(p);
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s got %h need %h", name, act, req);
   endtask

   // Queue the expected outputs for one frame, then produce the frame
   task automatic frame(input logic [15:0] b, input logic [7:0] x, input logic [7:0] y,
                        input logic [4:0] udlrf, input logic an, input logic af);
      m_pad  = pad_next(m_pad, x, b[10] & ~last_b[10]);
      last_b = b;
      @(posedge clk); #1;
      ds2_btn = b; ds2_lx = x; ds2_ly = y;
      exp_q.push_back(mk(udlrf, m_pad, PADDLE_BUILT & b[13], an, af));
      tag_q.push_back(n_frames++);
      repeat (10) @(posedge clk);
      #1 vsync = 1'b1;
      repeat (4) @(posedge clk);
      #1 vsync = 1'b0;
      repeat (6) @(posedge clk);
   endtask

   // Monitor: every frame_tick is matched against the oldest queued expectation
   always @(negedge clk) begin
      if (rst_n && frame_tick) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_tick got tick need none");
         end else begin
            check($sformatf("frame%0d", tag_q.pop_front()), got, exp_q.pop_front());
         end
      end
   end

   initial begin
      #400000;
      n_checks++;
      $display("FAIL timeout got running need finished");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", got, mk(5'b0, 8'h80, 1'b0, 1'b0, 1'b0));
      check("reset_tick", {15'h0, frame_tick}, 16'h0);
      rst_n = 1'b1;

      // Mode toggle and analog left
      frame(16'h0, 8'h80, 8'h80, 5'b0, 0, 0);
      frame(SEL,         8'h20, 8'h80, 5'b0, 0, 0);
      frame(SEL | START, 8'h20, 8'h80, L, 1, 0);
      frame(SEL,         8'h20, 8'h80, L, 1, 0);
      frame(16'h0,       8'h20, 8'h80, L, 1, 0);
      frame(SEL,         8'h20, 8'h80, L, 1, 0);
      frame(SEL | START, 8'h20, 8'h80, 5'b0, 0, 0);
      frame(16'h0,       8'h80, 8'h80, 5'b0, 0, 0);

      // Direction cancel and stick thresholds
      frame(LEFT | RIGHT,      8'h80, 8'h80, 5'b0, 0, 0);
      frame(LEFT | RIGHT | UP, 8'h80, 8'h80, U, 0, 0);
      frame(UP | DOWN | LEFT,  8'h80, 8'h80, L, 0, 0);
      frame(SEL,               8'h80, 8'h80, 5'b0, 0, 0);
      frame(SEL | START,       8'h80, 8'h80, 5'b0, 1, 0);
      frame(16'h0, 8'h60, 8'h80, 5'b0, 1, 0);
      frame(16'h0, 8'h5F, 8'h80, L, 1, 0);
      frame(16'h0, 8'h9F, 8'h80, 5'b0, 1, 0);
      frame(16'h0, 8'hA0, 8'h80, R, 1, 0);
      frame(16'h0, 8'h80, 8'h5F, U, 1, 0);
      frame(16'h0, 8'h80, 8'hA0, D, 1, 0);
      frame(RIGHT, 8'h20, 8'h80, 5'b0, 1, 0);
      frame(SEL,         8'h80, 8'h80, 5'b0, 1, 0);
      frame(SEL | START, 8'h80, 8'h80, 5'b0, 0, 0);
      frame(16'h0,       8'h80, 8'h80, 5'b0, 0, 0);

      // Autofire: 0000111100001111, then CROSS forces steady fire
      for (int i = 0; i < 16; i++)
         frame(R1 | SQUARE, 8'h80, 8'h80, ((i / 4) % 2 == 1) ? F : 5'b0, 0, 1);
      for (int i = 0; i < 4; i++)
         frame(R1 | SQUARE | CROSS, 8'h80, 8'h80, F, 0, 1);

      // Asynchronous reset mid-frame with autofire active
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      check("midframe_reset", got, mk(5'b0, 8'h80, 1'b0, 1'b0, 1'b0));
      ds2_btn = 16'h0; ds2_lx = 8'h80; ds2_ly = 8'h80;
      m_pad = 8'h80; last_b = 16'h0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      frame(16'h0, 8'h80, 8'h80, 5'b0, 0, 0);

      // Paddle: climb to saturation, recentre, fire, then descend to 0
      for (int i = 0; i < 12; i++)
         frame(16'h0, 8'hFF, 8'h80, 5'b0, 0, 0);
      frame(L1,    8'hFF, 8'h80, 5'b0, 0, 0);
      frame(L1,    8'hFF, 8'h80, 5'b0, 0, 0);
      frame(CIRC,  8'h80, 8'h80, 5'b0, 0, 0);
      for (int i = 0; i < 10; i++)
         frame(16'h0, 8'h00, 8'h80, 5'b0, 0, 0);

      // Glitch on CROSS straddling the vsync edge is filtered out
      frame(16'h0, 8'h80, 8'h80, 5'b0, 0, 0);
      @(posedge clk); #1;
      exp_q.push_back(mk(5'b0, m_pad, 1'b0, 1'b0, 1'b0));
      tag_q.push_back(n_frames++);
      repeat (9) @(posedge clk);
      #1 ds2_btn[14] = 1'b1;
      @(posedge clk);
      #1 vsync = 1'b1;
      @(posedge clk);
      #1 ds2_btn[14] = 1'b0;
      repeat (3) @(posedge clk);
      #1 vsync = 1'b0;
      repeat (6) @(posedge clk);
      frame(16'h0, 8'h80, 8'h80, 5'b0, 0, 0);

      repeat (30) @(posedge clk);
      #1;
      check("queue_drained", 16'(exp_q.size()), 16'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
